// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the chunked pipelined adder.
// Holds default geometry, op encoding and the stage-count derivation.
package pipe_adder_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CHUNK = 16;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int stages_of(
    input int width,
    input int chunk
  );
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipe_adder_chunk.sv
// chunk_adder: WIDTH-bit ripple-carry adder, one per pipeline stage.
// Ports: a, b, c_in -> sum, c_out, c_msb (carry into the top bit).
module chunk_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             c_msb
);

  logic [WIDTH:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = c_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out = c[WIDTH];
  assign c_msb = c[WIDTH-1];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: add/sub pipelined CHUNK bits per stage, valid/ready flow.
// Ports: clk, rst_n, in_*/a/b/c_in/sub in, out_*/sum/c_out/ovf out.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = stages_of(WIDTH, CHUNK);

  op_e  op;
  logic advance;

  // Level 0 holds captured, conditioned operands; level k+1 holds
  // the state after chunk k has been added.
  logic [STAGES:0] vld;
  logic [WIDTH-1:0] opa [STAGES];
  logic [WIDTH-1:0] opb [STAGES];
  logic [WIDTH-1:0] acc [STAGES+1];
  logic             cry [STAGES+1];
  logic             msb_q;

  logic [CHUNK-1:0] csum [STAGES];
  logic             cco  [STAGES];
  logic             cms  [STAGES];

  assign op = op_e'(sub);

  // The whole pipe moves or freezes together.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && rst_n;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    chunk_adder #(
      .WIDTH(CHUNK)
    ) u_add (
      .a    (opa[k][k*CHUNK +: CHUNK]),
      .b    (opb[k][k*CHUNK +: CHUNK]),
      .c_in (cry[k]),
      .sum  (csum[k]),
      .c_out(cco[k]),
      .c_msb(cms[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      msb_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        opa[k] <= '0;
        opb[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) begin
        acc[k] <= '0;
        cry[k] <= 1'b0;
      end
    end else if (advance) begin
      vld <= {vld[STAGES-1:0], in_valid};
      // Subtract is a + ~b + ~c_in: borrow-in inverts like b.
      opa[0] <= a;
      opb[0] <= (op == OP_SUB) ? ~b : b;
      cry[0] <= (op == OP_SUB) ? ~c_in : c_in;
      acc[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        opa[k] <= opa[k-1];
        opb[k] <= opb[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        acc[k+1] <= acc[k];
        acc[k+1][k*CHUNK +: CHUNK] <= csum[k];
        cry[k+1] <= cco[k];
      end
      msb_q <= cms[STAGES-1];
    end
  end

  assign out_valid = vld[STAGES];
  assign sum       = acc[STAGES];
  assign c_out     = cry[STAGES];
  assign ovf       = msb_q ^ cry[STAGES];

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder at 64/16 and 32/8 against an arithmetic model.
// Directed corner cases, stall, reset flush, then random traffic.
module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv_h, ir_h, ci_h, sb_h, ov_h, or_h, co_h, of_h;
  logic [63:0] a_h, b_h, s_h;
  logic        iv_l, ir_l, ci_l, sb_l, ov_l, or_l, co_l, of_l;
  logic [31:0] a_l, b_l, s_l;

  pipe_adder #(.WIDTH(64), .CHUNK(16)) u_h (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv_h), .in_ready(ir_h),
    .a(a_h), .b(b_h), .c_in(ci_h), .sub(sb_h),
    .out_valid(ov_h), .out_ready(or_h),
    .sum(s_h), .c_out(co_h), .ovf(of_h)
  );

  pipe_adder #(.WIDTH(32), .CHUNK(8)) u_l (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv_l), .in_ready(ir_l),
    .a(a_l), .b(b_l), .c_in(ci_l), .sub(sb_l),
    .out_valid(ov_l), .out_ready(or_l),
    .sum(s_l), .c_out(co_l), .ovf(of_l)
  );

  typedef struct packed {
    logic        c;
    logic        o;
    logic [63:0] s;
  } res_t;

  res_t q_h[$];
  res_t q_l[$];
  res_t e_h, e_l;
  int   n_chk = 0;
  int   n_err = 0;
  bit   error_flag = 1'b0;
  int   acc_h = 0, acc_l = 0, got_h = 0, got_l = 0;

  task automatic check(
    input string       tag,
    input logic [65:0] got,
    input logic [65:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      error_flag = 1'b1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic on w-bit operands.
  function automatic res_t model(
    input int          w,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        ci,
    input logic        op_sub
  );
    logic signed [71:0] one, mask, ua, ub, sa, sbv, c, r, s, hi, lo;
    res_t x;
    one  = 72'sd1;
    mask = (one <<< w) - one;
    ua   = {8'd0, a};
    ua   = ua & mask;
    ub   = {8'd0, b};
    ub   = ub & mask;
    sa   = ua[w-1] ? ua - (one <<< w) : ua;
    sbv  = ub[w-1] ? ub - (one <<< w) : ub;
    c    = {71'd0, ci};
    r    = op_sub ? (one <<< w) + ua - ub - c : ua + ub + c;
    s    = op_sub ? sa - sbv - c : sa + sbv + c;
    hi   = (one <<< (w - 1)) - one;
    lo   = -(one <<< (w - 1));
    x.s  = 64'(r & mask);
    x.c  = r[w];
    x.o  = (s > hi) || (s < lo);
    return x;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] m, v;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0:       v = '1;
      1:       v = '0;
      2:       v = (64'd1 << (w - 1)) - 64'd1;
      3:       v = 64'd1 << (w - 1);
      4:       v = 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v & m;
  endfunction

  // Monitors: acceptance and drain both take effect at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (iv_h && ir_h) begin
        q_h.push_back(model(64, a_h, b_h, ci_h, sb_h));
        acc_h++;
      end
      if (ov_h && or_h) begin
        check("h_q", 66'(q_h.size() != 0), 66'd1);
        if (q_h.size() != 0) begin
          e_h = q_h.pop_front();
          check("h_res", {co_h, of_h, s_h}, e_h);
          got_h++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (iv_l && ir_l) begin
        q_l.push_back(model(32, {32'd0, a_l}, {32'd0, b_l}, ci_l, sb_l));
        acc_l++;
      end
      if (ov_l && or_l) begin
        check("l_q", 66'(q_l.size() != 0), 66'd1);
        if (q_l.size() != 0) begin
          e_l = q_l.pop_front();
          check("l_res", {co_l, of_l, 32'd0, s_l}, e_l);
          got_l++;
        end
      end
    end
  end

  always @(negedge rst_n) begin
    q_h.delete();
    q_l.delete();
  end

  // Entered and left at posedge+1; holds inputs until accepted.
  task automatic send_h(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        ci,
    input logic        s
  );
    int   n;
    logic r;
    iv_h = 1'b1;
    a_h  = a;
    b_h  = b;
    ci_h = ci;
    sb_h = s;
    n    = 0;
    r    = 1'b0;
    while (!r && n < 50) begin
      @(negedge clk);
      r = ir_h;
      @(posedge clk);
      #1;
      n++;
    end
    check("h_send", 66'(r), 66'd1);
  endtask

  task automatic single_h(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        ci,
    input logic        s,
    input logic [63:0] xs,
    input logic        xc,
    input logic        xo
  );
    int n;
    send_h(a, b, ci, s);
    iv_h = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov_h && n < 20);
    check("h_lat", 66'(n), 66'd5);
    check("h_dir", {co_h, of_h, s_h}, {xc, xo, xs});
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_h(input int nops);
    int n, start;
    start = acc_h;
    n = 0;
    while (acc_h - start < nops && n < 40000) begin
      iv_h = ($urandom_range(0, 4) != 0);
      a_h  = pick(64);
      b_h  = pick(64);
      ci_h = 1'($urandom_range(0, 1));
      sb_h = 1'($urandom_range(0, 1));
      or_h = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      n++;
    end
    iv_h = 1'b0;
    or_h = 1'b1;
    n = 0;
    while (q_h.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("h_rnd_cnt", 66'(acc_h - start), 66'(nops));
    check("h_rnd_drain", 66'(q_h.size()), 66'd0);
  endtask

  task automatic rnd_l(input int nops);
    int n, start;
    start = acc_l;
    n = 0;
    while (acc_l - start < nops && n < 40000) begin
      iv_l = ($urandom_range(0, 4) != 0);
      a_l  = 32'(pick(32));
      b_l  = 32'(pick(32));
      ci_l = 1'($urandom_range(0, 1));
      sb_l = 1'($urandom_range(0, 1));
      or_l = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      n++;
    end
    iv_l = 1'b0;
    or_l = 1'b1;
    n = 0;
    while (q_l.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("l_rnd_cnt", 66'(acc_l - start), 66'(nops));
    check("l_rnd_drain", 66'(q_l.size()), 66'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base, n;
    logic [65:0] held;
    rst_n = 1'b0;
    {iv_h, ci_h, sb_h, a_h, b_h} = '0;
    {iv_l, ci_l, sb_l, a_l, b_l} = '0;
    or_h = 1'b1;
    or_l = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ov", 66'(ov_h), 66'd0);
    check("rst_ir", 66'(ir_h), 66'd0);
    check("rst_out", {co_h, of_h, s_h}, 66'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    single_h('1, 64'd1, 1'b1, 1'b0, 64'd1, 1'b1, 1'b0);
    single_h(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
    single_h(64'd5, 64'd7, 1'b0, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    single_h(64'd0, 64'd1, 1'b0, 1'b1, '1, 1'b0, 1'b0);
    single_h(64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b1,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);

    base = got_h;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_h({$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        iv_h = 1'b0;
      end
      begin
        int k;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!ov_h && k < 30);
        check("h_first", 66'(ov_h), 66'd1);
        @(posedge clk);
        #1;
        or_h = 1'b0;
        held = {co_h, of_h, s_h};
        repeat (3) begin
          @(negedge clk);
          check("stall_rdy", 66'(ir_h), 66'd0);
          check("stall_vld", 66'(ov_h), 66'd1);
          check("stall_hold", {co_h, of_h, s_h}, held);
          @(posedge clk);
          #1;
        end
        or_h = 1'b1;
      end
    join
    n = 0;
    while (q_h.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_cnt", 66'(got_h - base), 66'd8);
    check("stall_drain", 66'(q_h.size()), 66'd0);

    for (int i = 0; i < 5; i++)
      send_h({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    iv_h = 1'b0;
    check("flush_pre", 66'(ov_h), 66'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("flush_ov", 66'(ov_h), 66'd0);
    check("flush_ir", 66'(ir_h), 66'd0);
    check("flush_out", {co_h, of_h, s_h}, 66'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov_h) n++;
    end
    check("flush_stale", 66'(n), 66'd0);
    @(posedge clk);
    #1;

    fork
      rnd_h(10000);
      rnd_l(10000);
    join

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
